// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID->EX pipeline register for the MIPS datapath, placed directly after the
//   register file. It captures the decode results (both read ports, register
//   specifiers, sign-extended immediate, control bundle) and hands them to EX
//   over a valid/ready handshake. A 2-entry skid buffer (main + skid) lets
//   in_ready be a flop instead of a combinational path from out_ready.
//
//   Optional feature: define ID_EX_WB_BYPASS_EN to forward same-cycle
//   register-file writes into the captured entry and into held entries.
//   Without it the wb_* ports are present but ignored.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   decode-side handshake (in_ready is registered)
//   in_rs/in_rt/in_rd   register specifiers; in_reg_dst picks rd (1) or rt (0)
//   in_rdata1/2         register file read data
//   in_imm16            raw immediate, sign-extended on capture
//   in_ctrl             opaque control bundle (CTRL_W bits)
//   flush               synchronous kill of held and incoming entries
//   wb_reg_write/addr/data  write-back port, used only for the bypass
//   out_valid/out_ready EX-side handshake
//   out_*               fields of the main entry
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic              in_reg_dst,
   input  logic [31:0]       in_rdata1,
   input  logic [31:0]       in_rdata2,
   input  logic [15:0]       in_imm16,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_addr,
   input  logic [31:0]       wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_rdata1,
   output logic [31:0]       out_rdata2,
   output logic [31:0]       out_imm32,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_dst,
   output logic [CTRL_W-1:0] out_ctrl
);

   typedef struct packed {
      logic [31:0]       rdata1;
      logic [31:0]       rdata2;
      logic [31:0]       imm32;
      logic [4:0]        rs;
      logic [4:0]        rt;
      logic [4:0]        dst;
      logic [CTRL_W-1:0] ctrl;
   } entry_t;

   // Encoding equals the number of entries held.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      MAIN  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t state, state_next;
   entry_t main_q, skid_q, main_d, skid_d;
   entry_t in_raw, in_cur, main_cur, skid_cur;
   logic   in_ready_q;
   logic   in_xfer, out_xfer;

   always_comb begin
      in_raw        = '0;
      in_raw.rdata1 = in_rdata1;
      in_raw.rdata2 = in_rdata2;
      in_raw.imm32  = {{16{in_imm16[15]}}, in_imm16};
      in_raw.rs     = in_rs;
      in_raw.rt     = in_rt;
      in_raw.dst    = in_reg_dst ? in_rd : in_rt;
      in_raw.ctrl   = in_ctrl;
   end

`ifdef ID_EX_WB_BYPASS_EN
   // A write to $0 never changes the architectural value, so it is not forwarded.
   function automatic entry_t wb_fix(input entry_t e, input logic we,
                                     input logic [4:0] addr, input logic [31:0] data);
      entry_t r;
      r = e;
      if (we && addr != 5'd0) begin
         if (e.rs == addr) r.rdata1 = data;
         if (e.rt == addr) r.rdata2 = data;
      end
      return r;
   endfunction

   // Held entries are refreshed every cycle so operands never go stale in a stall.
   assign in_cur   = wb_fix(in_raw, wb_reg_write, wb_addr, wb_data);
   assign main_cur = wb_fix(main_q, wb_reg_write, wb_addr, wb_data);
   assign skid_cur = wb_fix(skid_q, wb_reg_write, wb_addr, wb_data);
`else
   logic unused_wb;
   assign unused_wb = ^{wb_reg_write, wb_addr, wb_data};
   assign in_cur    = in_raw;
   assign main_cur  = main_q;
   assign skid_cur  = skid_q;
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = (state != EMPTY);
   assign in_xfer   = in_valid & in_ready_q;
   assign out_xfer  = out_valid & out_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_next = state;
      main_d     = main_cur;
      skid_d     = skid_cur;
      unique case (state)
         EMPTY: if (in_xfer) begin
            state_next = MAIN;
            main_d     = in_cur;
         end
         MAIN: unique case ({in_xfer, out_xfer})
            2'b11: main_d = in_cur;
            2'b10: begin
               state_next = SKID;
               skid_d     = in_cur;
            end
            2'b01:   state_next = EMPTY;
            default: ;
         endcase
         SKID: if (out_xfer) begin
            state_next = MAIN;
            main_d     = skid_cur;
         end
         default: state_next = EMPTY;
      endcase
      // Flush wins over any handshake; EX discards its side through its own flush.
      if (flush) state_next = EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the entry registers are reset because the outputs must read 0 out of reset.
         state      <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
         state      <= state_next;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_next != SKID);
      end
   end

   assign out_rdata1 = main_q.rdata1;
   assign out_rdata2 = main_q.rdata2;
   assign out_imm32  = main_q.imm32;
   assign out_rs     = main_q.rs;
   assign out_rt     = main_q.rt;
   assign out_dst    = main_q.dst;
   assign out_ctrl   = main_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. The reference model is a bounded
//   FIFO (capacity 2) of expected entries; directed scenarios cover streaming,
//   backpressure, immediate/destination, flush, bypass and mid-stream reset,
//   followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic        in_reg_dst;
   logic [31:0] in_rdata1, in_rdata2;
   logic [15:0] in_imm16;
   logic [7:0]  in_ctrl;
   logic        flush;
   logic        wb_reg_write;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid, out_ready;
   logic [31:0] out_rdata1, out_rdata2, out_imm32;
   logic [4:0]  out_rs, out_rt, out_dst;
   logic [7:0]  out_ctrl;

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic [31:0] rdata1, rdata2, imm32;
      logic [4:0]  rs, rt, dst;
      logic [7:0]  ctrl;
   } exp_t;

   exp_t mq[$];

   id_ex_stage #(.CTRL_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_reg_dst(in_reg_dst),
      .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
      .in_imm16(in_imm16), .in_ctrl(in_ctrl),
      .flush(flush),
      .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_imm32(out_imm32),
      .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst), .out_ctrl(out_ctrl)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Entry the stage should hold for the current input values.
   function automatic exp_t make_entry();
      exp_t e;
      e.rdata1 = in_rdata1;
      e.rdata2 = in_rdata2;
      e.imm32  = 32'(signed'(in_imm16));
      e.rs     = in_rs;
      e.rt     = in_rt;
      e.dst    = (in_reg_dst == 1'b1) ? in_rd : in_rt;
      e.ctrl   = in_ctrl;
      return e;
   endfunction

   function automatic exp_t wb_apply(input exp_t e);
      exp_t r = e;
`ifdef ID_EX_WB_BYPASS_EN
      if (wb_reg_write && wb_addr != 0) begin
         if (e.rs == wb_addr) r.rdata1 = wb_data;
         if (e.rt == wb_addr) r.rdata2 = wb_data;
      end
`endif
      return r;
   endfunction

   task automatic compare_all();
      check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      if (mq.size() > 0) begin
         check("out_rdata1", out_rdata1, mq[0].rdata1);
         check("out_rdata2", out_rdata2, mq[0].rdata2);
         check("out_imm32", out_imm32, mq[0].imm32);
         check("out_rs", 32'(out_rs), 32'(mq[0].rs));
         check("out_rt", 32'(out_rt), 32'(mq[0].rt));
         check("out_dst", 32'(out_dst), 32'(mq[0].dst));
         check("out_ctrl", 32'(out_ctrl), 32'(mq[0].ctrl));
      end
   endtask

   // One clock: predict the next queue contents from the inputs already
   // driven (called while clk is low), then compare after the edge.
   task automatic cycle();
      exp_t nxt[$];
      bit   acc, pop;
      acc = in_valid && (mq.size() < 2);
      pop = (mq.size() > 0) && out_ready;
      nxt = mq;
      foreach (nxt[i]) nxt[i] = wb_apply(nxt[i]);
      if (flush) nxt.delete();
      else begin
         if (pop) void'(nxt.pop_front());
         if (acc) nxt.push_back(wb_apply(make_entry()));
      end
      @(posedge clk);
      mq = nxt;
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_reg_dst = 0;
      in_rdata1 = 0; in_rdata2 = 0; in_imm16 = 0; in_ctrl = 0;
      flush = 0; wb_reg_write = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
   endtask

   task automatic offer(input logic [31:0] d1);
      in_valid = 1; in_rdata1 = d1; in_rdata2 = ~d1;
      in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_reg_dst = 1;
      in_imm16 = d1[15:0]; in_ctrl = d1[7:0];
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_rdata1"}, out_rdata1, 32'd0);
      check({tag, "_rdata2"}, out_rdata2, 32'd0);
      check({tag, "_imm32"}, out_imm32, 32'd0);
      check({tag, "_fields"}, 32'({out_rs, out_rt, out_dst, out_ctrl}), 32'd0);
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;
      repeat (2) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1;
      @(negedge clk);
      compare_all();

      // Streaming: four back-to-back inputs, EX always ready.
      out_ready = 1;
      for (int k = 1; k <= 4; k++) begin
         offer(32'(k));
         cycle();
         check("stream_data", out_rdata1, 32'(k));
         check("stream_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 0;
      cycle();

      // Backpressure: A and B held, C stalls, then all three drain in order.
      out_ready = 0;
      offer(32'hA); cycle();
      offer(32'hB); cycle();
      check("bp_ready_low", 32'(in_ready), 32'd0);
      offer(32'hC); cycle();
      check("bp_head_a", out_rdata1, 32'hA);
      out_ready = 1;
      cycle();
      check("bp_head_b", out_rdata1, 32'hB);
      cycle();
      check("bp_head_c", out_rdata1, 32'hC);
      in_valid = 0;
      cycle();
      check("bp_drained", 32'(out_valid), 32'd0);

      // Immediate sign extension and destination select.
      offer(32'h0); in_imm16 = 16'h8001; in_reg_dst = 1; in_rd = 5'd9; in_rt = 5'd4;
      cycle();
      check("imm_sext", out_imm32, 32'hFFFF8001);
      check("dst_rd", 32'(out_dst), 32'd9);
      in_reg_dst = 0;
      cycle();
      check("dst_rt", 32'(out_dst), 32'd4);
      in_valid = 0;
      cycle();

      // Flush while in SKID with an input offered.
      out_ready = 0;
      offer(32'h21); cycle();
      offer(32'h22); cycle();
      offer(32'h99); flush = 1;
      cycle();
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_ready", 32'(in_ready), 32'd1);
      flush = 0; in_valid = 0; out_ready = 1;
      repeat (2) begin
         cycle();
         check("flush_no_ghost", 32'(out_valid), 32'd0);
      end

      // Write-back bypass on capture and on a held entry.
      out_ready = 0;
      offer(32'h1); in_rdata2 = 32'h2; in_rs = 5'd3; in_rt = 5'd7;
      wb_reg_write = 1; wb_addr = 5'd3; wb_data = 32'hCAFE;
      cycle();
      in_valid = 0; wb_addr = 5'd7; wb_data = 32'h55;
      cycle();
`ifdef ID_EX_WB_BYPASS_EN
      check("byp_capture_rs", out_rdata1, 32'hCAFE);
      check("byp_held_rt", out_rdata2, 32'h55);
`else
      check("nobyp_rs", out_rdata1, 32'h1);
      check("nobyp_rt", out_rdata2, 32'h2);
`endif
      wb_addr = 5'd0; wb_data = 32'hDEAD;
      out_ready = 1;
      cycle();
      offer(32'h11); in_rs = 5'd0; in_rt = 5'd0; in_rdata2 = 32'h12;
      cycle();
      check("byp_r0_rs", out_rdata1, 32'h11);
      check("byp_r0_rt", out_rdata2, 32'h12);
      in_valid = 0; wb_reg_write = 0;
      cycle();

      // Randomized run against the FIFO model.
      for (int n = 0; n < 400; n++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         out_ready    = ($urandom_range(0, 2) != 0);
         flush        = ($urandom_range(0, 15) == 0);
         in_rs        = 5'($urandom_range(0, 7));
         in_rt        = 5'($urandom_range(0, 7));
         in_rd        = 5'($urandom);
         in_reg_dst   = 1'($urandom);
         in_rdata1    = $urandom;
         in_rdata2    = $urandom;
         in_imm16     = 16'($urandom);
         in_ctrl      = 8'($urandom);
         wb_reg_write = 1'($urandom);
         wb_addr      = 5'($urandom_range(0, 7));
         wb_data      = $urandom;
         cycle();
      end

      // Asynchronous reset mid-stream with two entries held.
      idle_inputs();
      offer(32'h31); cycle();
      offer(32'h32); cycle();
      check("pre_reset_full", 32'(in_ready), 32'd0);
      rst_n = 0;
      #1;
      mq.delete();
      check_zero_outputs("async_reset");
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
      cycle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
